// File: rtl/mem_arb_pkg.sv
// ============================================================================
// Module : mem_arb_pkg
// Brief  : Shared types and constants for the I/D cache memory arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_BLOCK_W = 256;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10,
        DONE  = 2'b11
    } arb_state_e;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arb_rr2.sv
// ============================================================================
// Module : arb_rr2
// Brief  : Combinational two-way round-robin pick (bit 0 = icache, 1 = dcache).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic       grant_o,
    output logic       valid_o
);

    always_comb begin
        valid_o = |req_i;
        grant_o = GRANT_I;
        // On a tie the requester that did not win last time takes the slot.
        if (req_i == 2'b11) begin
            grant_o = (last_i == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (req_i[1]) begin
            grant_o = GRANT_D;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// Module : mem_arbiter
// Brief  : Arbitrates I-cache refills and D-cache refills/writebacks onto one
//          main-memory port.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int BLOCK_W = DEF_BLOCK_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               ic_req,
    input  logic [ADDR_W-1:0]  ic_addr,
    output logic [BLOCK_W-1:0] ic_rdata,
    output logic               ic_done,
    input  logic               dc_req,
    input  logic               dc_we,
    input  logic [ADDR_W-1:0]  dc_addr,
    input  logic [BLOCK_W-1:0] dc_wdata,
    output logic [BLOCK_W-1:0] dc_rdata,
    output logic               dc_done,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata,
    input  logic               mem_ready,
    output logic               busy
);

    arb_state_e         state_q;
    logic               last_q;
    logic               mem_req_q;
    logic               mem_we_q;
    logic [ADDR_W-1:0]  mem_addr_q;
    logic [BLOCK_W-1:0] mem_wdata_q;
    logic [BLOCK_W-1:0] ic_rdata_q;
    logic [BLOCK_W-1:0] dc_rdata_q;
    logic               ic_done_q;
    logic               dc_done_q;

    logic               arb_grant;
    logic               arb_valid;

    arb_rr2 u_arb (
        .req_i   ({dc_req, ic_req}),
        .last_i  (last_q),
        .grant_o (arb_grant),
        .valid_o (arb_valid)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            last_q      <= GRANT_I;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ic_rdata_q  <= '0;
            dc_rdata_q  <= '0;
            ic_done_q   <= 1'b0;
            dc_done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (arb_valid) begin
                        last_q    <= arb_grant;
                        mem_req_q <= 1'b1;
                        // The memory-side registers double as the granted port's copy.
                        if (arb_grant == GRANT_D) begin
                            state_q     <= GNT_D;
                            mem_addr_q  <= dc_addr;
                            mem_we_q    <= dc_we;
                            mem_wdata_q <= dc_we ? dc_wdata : '0;
                        end else begin
                            state_q     <= GNT_I;
                            mem_addr_q  <= ic_addr;
                            mem_we_q    <= 1'b0;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                GNT_I: begin
                    if (mem_ready) begin
                        ic_rdata_q  <= mem_rdata;
                        ic_done_q   <= 1'b1;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= '0;
                        state_q     <= DONE;
                    end
                end
                GNT_D: begin
                    if (mem_ready) begin
                        if (!mem_we_q) begin
                            dc_rdata_q <= mem_rdata;
                        end
                        dc_done_q   <= 1'b1;
                        mem_req_q   <= 1'b0;
                        mem_we_q    <= 1'b0;
                        mem_wdata_q <= '0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    ic_done_q <= 1'b0;
                    dc_done_q <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign ic_rdata  = ic_rdata_q;
    assign dc_rdata  = dc_rdata_q;
    assign ic_done   = ic_done_q;
    assign dc_done   = dc_done_q;
    assign busy      = (state_q != IDLE);

endmodule

`default_nettype wire
